// File: rtl/muldiv_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit: op encodings,
// controller states and the iteration count. The ALU decoder imports the
// same op constants so both agree on the encoding.
package muldiv_pkg;

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  // One bit of product/quotient is resolved per RUN cycle.
  localparam int STEPS = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIX  = 2'd2
  } state_t;

  // Signed ops take operand magnitudes and fix the result sign afterwards.
  function automatic logic op_is_signed(input logic [1:0] op);
    return (op == OP_MULT) || (op == OP_DIV);
  endfunction

  function automatic logic op_is_div(input logic [1:0] op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

endpackage

// File: rtl/muldiv_unit.sv
// Iterative HI/LO multiply/divide unit (mult, multu, div, divu, mthi, mtlo).
// One shared {rem, q} register pair and a single 33-bit adder serve both
// shift-add multiplication and restoring division. Every operation takes
// 33 cycles: 32 RUN steps plus one FIX cycle that applies the result sign
// and writes HI/LO.
//
// Handshake: start is a request sampled only in IDLE; busy is the "not
// ready" indication, high from the edge after start is taken until the
// edge that writes HI/LO. start/mthi/mtlo are ignored while busy, and
// A/B/op may change freely then because latched copies are used.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             mthi,
  input  logic             mtlo,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic [1:0]       dbg_state
);

  localparam int              CNT_W     = $clog2(STEPS);
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(STEPS - 1);

  state_t             r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [WIDTH-1:0]   r_rem;     // product upper half / partial remainder
  logic [WIDTH-1:0]   r_q;       // multiplier-then-product low / dividend-then-quotient
  logic [WIDTH-1:0]   r_b;       // multiplicand / divisor magnitude
  logic               r_is_div;
  logic               r_neg_q;
  logic               r_neg_r;
  logic               r_dz;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;

  logic               w_a_neg;
  logic               w_b_neg;
  logic [WIDTH-1:0]   w_a_mag;
  logic [WIDTH-1:0]   w_b_mag;
  logic [WIDTH:0]     w_add_a;
  logic [WIDTH:0]     w_add_b;
  logic [WIDTH:0]     w_sum;
  logic               w_ge;
  logic [2*WIDTH-1:0] w_prod;
  logic [2*WIDTH-1:0] w_prod_fix;
  logic [WIDTH-1:0]   w_quo_fix;
  logic [WIDTH-1:0]   w_rem_fix;

  assign busy      = (r_state != ST_IDLE);
  assign dbg_state = r_state;
  assign hi        = r_hi;
  assign lo        = r_lo;

  // Operand magnitudes for launch; unsigned ops pass the raw operands.
  always_comb begin
    w_a_neg = op_is_signed(op) & A[WIDTH-1];
    w_b_neg = op_is_signed(op) & B[WIDTH-1];
    w_a_mag = w_a_neg ? -A : A;
    w_b_mag = w_b_neg ? -B : B;
  end

  // Shared 33-bit adder: add-or-skip multiplicand for multiply, trial
  // subtract of the divisor (a + ~b + 1) for divide.
  always_comb begin
    if (r_is_div) begin
      w_add_a = {r_rem, r_q[WIDTH-1]};
      w_add_b = ~{1'b0, r_b};
    end else begin
      w_add_a = {1'b0, r_rem};
      w_add_b = r_q[0] ? {1'b0, r_b} : '0;
    end
    w_sum = w_add_a + w_add_b + {{WIDTH{1'b0}}, r_is_div};
    // The partial remainder stays below the divisor, so bit WIDTH of the
    // trial difference is a clean borrow flag.
    w_ge  = ~w_sum[WIDTH];
  end

  // Result sign fix. With a zero divisor the magnitude path leaves
  // rem = |A| and q = all ones, so re-applying A's sign to rem restores
  // the original A for HI while LO is forced to all ones.
  always_comb begin
    w_prod     = {r_rem, r_q};
    w_prod_fix = r_neg_q ? -w_prod : w_prod;
    w_quo_fix  = r_dz ? '1 : (r_neg_q ? -r_q : r_q);
    w_rem_fix  = r_neg_r ? -r_rem : r_rem;
  end

  // Controller and datapath: IDLE handles moves and launch, RUN steps one
  // bit per cycle, FIX writes the signed result to HI/LO.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_cnt    <= '0;
      r_rem    <= '0;
      r_q      <= '0;
      r_b      <= '0;
      r_is_div <= 1'b0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_dz     <= 1'b0;
      r_hi     <= '0;
      r_lo     <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_rem    <= '0;
            r_q      <= w_a_mag;
            r_b      <= w_b_mag;
            r_is_div <= op_is_div(op);
            r_neg_q  <= w_a_neg ^ w_b_neg;
            r_neg_r  <= w_a_neg;
            r_dz     <= op_is_div(op) & (B == '0);
            r_cnt    <= '0;
            r_state  <= ST_RUN;
          end else begin
            if (mthi) r_hi <= A;
            if (mtlo) r_lo <= A;
          end
        end
        ST_RUN: begin
          if (r_is_div) begin
            r_rem <= w_ge ? w_sum[WIDTH-1:0] : w_add_a[WIDTH-1:0];
            r_q   <= {r_q[WIDTH-2:0], w_ge};
          end else begin
            r_rem <= w_sum[WIDTH:1];
            r_q   <= {w_sum[0], r_q[WIDTH-1:1]};
          end
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == LAST_STEP) r_state <= ST_FIX;
        end
        ST_FIX: begin
          if (r_is_div) begin
            r_hi <= w_rem_fix;
            r_lo <= w_quo_fix;
          end else begin
            r_hi <= w_prod_fix[2*WIDTH-1:WIDTH];
            r_lo <= w_prod_fix[WIDTH-1:0];
          end
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: a table of operations with hand-computed
// HI/LO results, plus sequences for moves, ignored requests while busy,
// back-to-back relaunch and asynchronous reset mid-operation.
module tb_muldiv_unit;
  import muldiv_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [1:0]  op;
  logic [31:0] A;
  logic [31:0] B;
  logic        mthi;
  logic        mtlo;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic [1:0]  dbg_state;

  int total;
  int bad;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  localparam int NVEC = 18;
  vec_t vecs [NVEC];

  muldiv_unit #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .op        (op),
    .A         (A),
    .B         (B),
    .mthi      (mthi),
    .mtlo      (mtlo),
    .hi        (hi),
    .lo        (lo),
    .busy      (busy),
    .dbg_state (dbg_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive a start at the next falling edge; returns just after the
  // accepting rising edge, with start still high.
  task automatic launch(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    start = 1'b1;
    op    = o;
    A     = a;
    B     = b;
    @(posedge clk);
    #1;
  endtask

  // Count cycles busy stays high (starting at 1 for the cycle already
  // seen high); bounded so a stuck unit still reaches the summary.
  task automatic wait_done(output int cyc);
    cyc = 1;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      #1;
      if (!busy) return;
      cyc++;
    end
    chk("timeout_busy", 32'(busy), 32'd0);
  endtask

  // Full operation with scrambled inputs while busy.
  task automatic run_op(input string name, input logic [1:0] o,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] ehi, input logic [31:0] elo);
    int cyc;
    launch(o, a, b);
    chk({name, "_busy_after_start"}, 32'(busy), 32'd1);
    @(negedge clk);
    start = 1'b0;
    op    = 2'($urandom_range(0, 3));
    A     = $urandom;
    B     = $urandom;
    wait_done(cyc);
    chk({name, "_latency"}, 32'(cyc), 32'd33);
    chk({name, "_hi"}, hi, ehi);
    chk({name, "_lo"}, lo, elo);
  endtask

  initial begin
    int cyc;
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    start = 1'b0;
    op    = 2'b00;
    A     = '0;
    B     = '0;
    mthi  = 1'b0;
    mtlo  = 1'b0;

    vecs[0]  = '{OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
    vecs[1]  = '{OP_MULT,  32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB};
    vecs[2]  = '{OP_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD};
    vecs[3]  = '{OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
    vecs[4]  = '{OP_DIVU,  32'h00000005, 32'h00000000, 32'h00000005, 32'hFFFFFFFF};
    vecs[5]  = '{OP_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
    vecs[6]  = '{OP_MULTU, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000};
    vecs[7]  = '{OP_MULT,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001};
    vecs[8]  = '{OP_MULT,  32'h00000000, 32'hFFFFFFFB, 32'h00000000, 32'h00000000};
    vecs[9]  = '{OP_MULT,  32'h7FFFFFFF, 32'h00000002, 32'h00000000, 32'hFFFFFFFE};
    vecs[10] = '{OP_DIVU,  32'h00000064, 32'h00000007, 32'h00000002, 32'h0000000E};
    vecs[11] = '{OP_DIV,   32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};
    vecs[12] = '{OP_DIV,   32'hFFFFFFF8, 32'hFFFFFFFD, 32'hFFFFFFFE, 32'h00000002};
    vecs[13] = '{OP_DIVU,  32'hFFFFFFFF, 32'h00000001, 32'h00000000, 32'hFFFFFFFF};
    vecs[14] = '{OP_DIVU,  32'hFFFFFFFF, 32'h80000000, 32'h7FFFFFFF, 32'h00000001};
    vecs[15] = '{OP_DIV,   32'hFFFFFFFB, 32'h00000000, 32'hFFFFFFFB, 32'hFFFFFFFF};
    vecs[16] = '{OP_DIV,   32'h80000000, 32'h00000000, 32'h80000000, 32'hFFFFFFFF};
    vecs[17] = '{OP_DIVU,  32'h00000003, 32'h0000000A, 32'h00000003, 32'h00000000};

    // Reset state
    repeat (2) @(negedge clk);
    chk("reset_hi", hi, 32'h0);
    chk("reset_lo", lo, 32'h0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_state", 32'(dbg_state), 32'(ST_IDLE));
    rst_n = 1'b1;

    // Table-driven operations
    for (int i = 0; i < NVEC; i++)
      run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].hi, vecs[i].lo);

    // mthi / mtlo in IDLE, one-edge latency, both together
    @(negedge clk);
    mthi = 1'b1; A = 32'h00001234;
    @(posedge clk); #1;
    chk("mthi_hi", hi, 32'h00001234);
    @(negedge clk);
    mthi = 1'b0; mtlo = 1'b1; A = 32'h00005678;
    @(posedge clk); #1;
    chk("mtlo_lo", lo, 32'h00005678);
    chk("mtlo_hi_kept", hi, 32'h00001234);
    @(negedge clk);
    mthi = 1'b1; mtlo = 1'b1; A = 32'hCAFEF00D;
    @(posedge clk); #1;
    chk("mthilo_hi", hi, 32'hCAFEF00D);
    chk("mthilo_lo", lo, 32'hCAFEF00D);
    @(negedge clk);
    mthi = 1'b0; mtlo = 1'b0;

    // start together with mthi: the move is dropped
    @(negedge clk);
    mthi = 1'b1;
    launch(OP_MULTU, 32'h2, 32'h3);
    chk("start_mthi_hi_kept", hi, 32'hCAFEF00D);
    chk("start_mthi_state", 32'(dbg_state), 32'(ST_RUN));
    @(negedge clk);
    start = 1'b0; mthi = 1'b0;
    wait_done(cyc);
    chk("start_mthi_hi", hi, 32'h0);
    chk("start_mthi_lo", lo, 32'h6);

    // mtlo and a second start mid-RUN are ignored
    launch(OP_MULTU, 32'h3, 32'h5);
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    mtlo = 1'b1; start = 1'b1; op = OP_DIV; A = 32'hDEAD; B = 32'h7;
    @(negedge clk);
    mtlo = 1'b0; start = 1'b0;
    chk("midrun_lo_untouched", lo, 32'h6);
    wait_done(cyc);
    chk("midrun_latency", 32'(cyc + 6), 32'd33);
    chk("midrun_hi", hi, 32'h0);
    chk("midrun_lo", lo, 32'hF);

    // Held start: not taken at the FIX edge, taken one edge later
    launch(OP_MULTU, 32'h2, 32'h2);
    wait_done(cyc);
    chk("b2b_latency", 32'(cyc), 32'd33);
    chk("b2b_lo_first", lo, 32'h4);
    A = 32'h3; B = 32'h3;
    @(posedge clk); #1;
    chk("b2b_relaunch_busy", 32'(busy), 32'd1);
    @(negedge clk);
    start = 1'b0;
    wait_done(cyc);
    chk("b2b_latency2", 32'(cyc), 32'd33);
    chk("b2b_lo_second", lo, 32'h9);

    // Asynchronous reset at step 10 of a mult
    @(negedge clk);
    mthi = 1'b1; mtlo = 1'b1; A = 32'hAAAA5555;
    @(negedge clk);
    mthi = 1'b0; mtlo = 1'b0;
    launch(OP_MULT, 32'h7, 32'h9);
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_hi", hi, 32'h0);
    chk("rst_mid_lo", lo, 32'h0);
    chk("rst_mid_busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op("after_rst", OP_MULT, 32'h7, 32'h9, 32'h0, 32'd63);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative multiply/divide unit that produces the HI/LO register pair. It executes MIPS `mult`, `multu`, `div` and `divu`, and services `mthi`/`mtlo` writes. Its `hi`/`lo` outputs drive the ALU's mfhi/mflo operand inputs. It sits beside the ALU in the EX stage, and the pipeline stalls any HI/LO consumer while `busy` is high.

## Interface
- `WIDTH`, default 32: operand and HI/LO width. Only 32 is supported.
- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `start` input 1: launch the operation selected by `op`. Honoured only in IDLE.
- `op` input 2: `00` mult, `01` multu, `10` div, `11` divu.
- `A` input 32: rs operand (multiplicand/dividend), and the data source for mthi/mtlo.
- `B` input 32: rt operand (multiplier/divisor).
- `mthi` input 1: write `A` into HI.
- `mtlo` input 1: write `A` into LO.
- `hi` output 32: HI register (remainder / product upper half).
- `lo` output 32: LO register (quotient / product lower half).
- `busy` output 1: high whenever the state is not IDLE. Decoded directly from the state register.

## Operation
- States are IDLE, RUN and FIX.
- **IDLE**
  - `start` takes priority over `mthi`/`mtlo` in the same cycle; the move is dropped.
  - Otherwise `mthi`/`mtlo` write `A` into HI/LO at the edge. Both may be high together.
- **Launch (IDLE with `start`)**
  - Latch the operand magnitudes. Signed ops use two's-complement absolute value; unsigned ops use the raw operands.
  - Latch `neg_q` = A[31]^B[31] and `neg_r` = A[31]. Both are latched only for signed ops and forced to 0 for unsigned ops.
  - Latch `dz` = (B == 0) for div/divu.
  - Clear the 5-bit step counter and go to RUN.
- **RUN, 32 steps, one bit per cycle**
  - Multiply: radix-2 shift-add into a 64-bit accumulator, giving the unsigned 64-bit product of the magnitudes.
  - Divide: restoring division with a 33-bit trial subtract, giving a 32-bit quotient and remainder.
  - When counter == 31, go to FIX.
- **FIX, one cycle**
  - Mult: if `neg_q`, negate the 64-bit product. HI = [63:32], LO = [31:0].
  - Div: LO = quotient, negated if `neg_q`. HI = remainder, negated if `neg_r`.
  - Divide by zero (`dz`): LO = 32'hFFFFFFFF and HI = original `A`, for both signed and unsigned ops. No sign fix is applied.
  - 0x80000000 / -1 (signed): LO = 0x80000000, HI = 0. This falls out of the magnitude path naturally.
  - Go to IDLE.
- **While busy**
  - `start`, `mthi` and `mtlo` are ignored.
  - `A`, `B` and `op` may change freely; the latched copies are used.
- **Reset**
  - Asynchronous assertion at any time, including mid-RUN, forces IDLE, `hi` = 0, `lo` = 0, `busy` = 0, counter = 0.
  - The aborted result is discarded.

## Timing
- `start` is sampled at edge k, with the unit in IDLE.
- `busy` is high from just after edge k until just after edge k+33.
- RUN occupies edges k+1 through k+32. FIX is evaluated at edge k+33, where HI/LO are written.
- New `hi`/`lo` are visible after edge k+33, which is the same edge at which `busy` falls.
- Latency is 33 cycles, identical for every op and every operand value. There is no early termination.
- Back-to-back: a `start` at edge k+33 is not accepted, because the state is still FIX. The earliest accepted relaunch is edge k+34.
- `mthi`/`mtlo` have a one-edge latency; the new value is visible after the write edge.
- `hi`, `lo` and `busy` are all registered or state-decoded. There are no combinational paths from the inputs.

## Structure
- A shared package `muldiv_pkg` holds:
  - op encodings `OP_MULT`, `OP_MULTU`, `OP_DIV`, `OP_DIVU`;
  - the state enum (IDLE/RUN/FIX);
  - the `STEPS` = 32 constant.
- The ALU decoder imports the same op constants.
- No sub-module. A single module with one datapath serves both ops:
  - shared 64-bit {rem, q/acc} register;
  - 33-bit adder/subtractor;
  - negation logic reused for operand magnitude and result fix.
- Expected size is about 200 lines.

## Test plan
- multu A=0xFFFFFFFF B=0xFFFFFFFF → after 33 cycles hi=0xFFFFFFFE, lo=0x00000001. `busy` is high for exactly 33 cycles.
- mult A=-3 (0xFFFFFFFD) B=7 → hi=0xFFFFFFFF, lo=0xFFFFFFEB.
- div A=-7 B=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- div A=0x80000000 B=0xFFFFFFFF → lo=0x80000000, hi=0.
- divu A=5 B=0 → lo=0xFFFFFFFF, hi=5.
- Control edge cases:
  - mthi A=0x1234 in IDLE → hi=0x1234 next cycle.
  - mtlo or a second `start` pulsed mid-RUN → ignored, result unchanged.
  - `start` together with `mthi` in IDLE → `mthi` dropped.
  - `rst_n` low at step 10 of a mult → `hi`/`lo`/`busy` = 0 immediately. A fresh `start` after release completes normally.
